// File: rtl/nfc_pkg.sv
// Shared definitions for the NFC key unlock block.
//   KEY_SEQ  : unlock digit sequence K0..K7 (KEY_SEQ[n] = Kn)
//   WTMK_KEY : digit that arms the watermark path when seen in S7
//   state_e  : FSM state encoding (S0..S7 = next expected digit index)
package nfc_pkg;

  localparam int unsigned KEY_W      = 4;
  localparam int unsigned NUM_DIGITS = 8;

  // K0 sits in the lowest slot so KEY_SEQ[n] is digit Kn.
  localparam logic [NUM_DIGITS-1:0][KEY_W-1:0] KEY_SEQ = {
    4'h4, 4'h4, 4'h0, 4'h5, 4'h9, 4'h5, 4'h0, 4'h5
  };

  localparam logic [KEY_W-1:0] WTMK_KEY = 4'hF;

  // S0..S7 occupy codes 0..7 so the low three bits index KEY_SEQ.
  typedef enum logic [3:0] {
    ST_S0       = 4'd0,
    ST_S1       = 4'd1,
    ST_S2       = 4'd2,
    ST_S3       = 4'd3,
    ST_S4       = 4'd4,
    ST_S5       = 4'd5,
    ST_S6       = 4'd6,
    ST_S7       = 4'd7,
    ST_UNLOCKED = 4'd8,
    ST_LOCKED   = 4'd9
  } state_e;

endpackage

// File: rtl/nfc_key_unlock.sv
// NFC key unlock: matches an 8-digit key sequence, one digit per clock, and
// enables the NFC core once the full sequence is seen. Mismatches after the
// first digit count as failures; MAX_FAIL failures lock the block until rst.
//
// Optional feature: define WATERMARK_EN to enable the watermark path (a 4'hF
// in place of K7 arms a flag; the next full sequence unlocks with wtmk=1).
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   KEY      in   key digit, sampled every clock while rst=0
//   unlock   out  registered, 1 = sequence accepted
//   wtmk     out  registered, 1 = unlocked through the watermark path
//   lockout  out  registered, 1 = MAX_FAIL failures reached
//   fail_cnt out  registered count of failed attempts (saturating)
module nfc_key_unlock
  import nfc_pkg::*;
#(
  parameter int unsigned MAX_FAIL = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [KEY_W-1:0]                KEY,
  output logic                            unlock,
  output logic                            wtmk,
  output logic                            lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int unsigned     FCW      = $clog2(MAX_FAIL + 1);
  localparam logic [FCW-1:0]  FAIL_MAX = FCW'(MAX_FAIL);

  state_e         state;
  state_e         state_next;
  logic           in_seq;
  logic           key_match;
  logic           wtmk_take;
  logic           fail_hit;
  logic           lock_hit;
  logic [FCW-1:0] fail_cnt_next;

`ifdef WATERMARK_EN
  logic           wtmk_flag;
`endif

  // Next-state and failure decode for the current sample.
  always_comb begin
    in_seq        = (state != ST_UNLOCKED) && (state != ST_LOCKED);
    key_match     = (KEY == KEY_SEQ[state[2:0]]);
`ifdef WATERMARK_EN
    wtmk_take     = in_seq && (state == ST_S7) && (KEY == WTMK_KEY) && !wtmk_flag;
`else
    wtmk_take     = 1'b0;
`endif
    // A mismatch in S0 just waits for K0; it is not an attempt.
    fail_hit      = in_seq && (state != ST_S0) && !key_match && !wtmk_take;
    fail_cnt_next = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FCW'(1);
    lock_hit      = fail_hit && (fail_cnt_next == FAIL_MAX);

    state_next = state;
    if (in_seq) begin
      if (key_match) begin
        state_next = (state == ST_S7) ? ST_UNLOCKED : state_e'(4'(state) + 4'd1);
      end else if (wtmk_take) begin
        state_next = ST_S0;
      end else if (lock_hit) begin
        state_next = ST_LOCKED;
      end else begin
        // The failing digit may itself start a new attempt.
        state_next = (KEY == KEY_SEQ[0]) ? ST_S1 : ST_S0;
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_S0;
      unlock   <= 1'b0;
      lockout  <= 1'b0;
      fail_cnt <= '0;
`ifdef WATERMARK_EN
      wtmk_flag <= 1'b0;
      wtmk      <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      unlock  <= (state == ST_UNLOCKED);
      lockout <= (state == ST_LOCKED);
      if (fail_hit) begin
        fail_cnt <= fail_cnt_next;
      end
`ifdef WATERMARK_EN
      if (wtmk_take) begin
        wtmk_flag <= 1'b1;
      end else if (fail_hit) begin
        wtmk_flag <= 1'b0;
      end
      wtmk <= (state == ST_UNLOCKED) && wtmk_flag;
`endif
    end
  end

`ifndef WATERMARK_EN
  assign wtmk = 1'b0;
`endif

endmodule

// File: tb/tb_nfc_key_unlock.sv
// Testbench for nfc_key_unlock (default MAX_FAIL=3). Expected output vectors
// {unlock, wtmk, lockout, fail_cnt} are queued as each input cycle is driven
// and compared one clock later. Watermark expectations follow WATERMARK_EN.
module tb_nfc_key_unlock;

  typedef logic [4:0] exp_t;
  typedef struct packed {
    logic       r;
    logic [3:0] k;
    exp_t       e;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       unlock;
  logic       wtmk;
  logic       lockout;
  logic [1:0] fail_cnt;

  exp_t  sb[$];
  step_t plan_q[$];
  int    passed = 0;
  int    total  = 0;

  always #5 clk = ~clk;

  nfc_key_unlock #(.MAX_FAIL(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .KEY      (key),
    .unlock   (unlock),
    .wtmk     (wtmk),
    .lockout  (lockout),
    .fail_cnt (fail_cnt)
  );

  function automatic logic [3:0] good_digit(input int i);
    case (i)
      0: return 4'h5;
      1: return 4'h0;
      2: return 4'h5;
      3: return 4'h9;
      4: return 4'h5;
      5: return 4'h0;
      6: return 4'h4;
      default: return 4'h4;
    endcase
  endfunction

  function automatic exp_t mk(input logic u, input logic w, input logic l, input int fc);
    return {u, w, l, 2'(fc)};
  endfunction

  task automatic plan(input logic r, input logic [3:0] k, input exp_t e);
    plan_q.push_back('{r: r, k: k, e: e});
  endtask

  task automatic plan_good(input int n, input exp_t e);
    for (int i = 0; i < n; i++) plan(1'b0, good_digit(i), e);
  endtask

  // Apply one input cycle and queue what the outputs must read after the edge.
  task automatic drive(input logic r, input logic [3:0] k, input exp_t e);
    rst = r;
    key = k;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t st;
    exp_t  e;
    int    n = 0;
    plan_q.delete();
    plan(1'b1, 4'h5, mk(0, 0, 0, 0));
    plan(1'b1, 4'h5, mk(0, 0, 0, 0));
    plan(1'b1, 4'h0, mk(0, 0, 0, 0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      drive(st.r, st.k, st.e);
      e = sb.pop_front();
      total++;
      if ({unlock, wtmk, lockout, fail_cnt} !== e)
        $display("FAIL reset step %0d: got u=%b w=%b l=%b fc=%0d, want %b", n, unlock, wtmk, lockout, fail_cnt, e);
      else passed++;
      n++;
    end
  endtask

  task automatic test_unlock();
    step_t st;
    exp_t  e;
    int    n = 0;
    plan_q.delete();
    plan(1'b1, 4'h0, mk(0, 0, 0, 0));
    plan_good(8, mk(0, 0, 0, 0));
    plan(1'b0, 4'h3, mk(1, 0, 0, 0));
    plan(1'b0, 4'h3, mk(1, 0, 0, 0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      drive(st.r, st.k, st.e);
      e = sb.pop_front();
      total++;
      if ({unlock, wtmk, lockout, fail_cnt} !== e)
        $display("FAIL unlock step %0d: got u=%b w=%b l=%b fc=%0d, want %b", n, unlock, wtmk, lockout, fail_cnt, e);
      else passed++;
      n++;
    end
  endtask

  task automatic test_idle_zero();
    step_t st;
    exp_t  e;
    int    n = 0;
    plan_q.delete();
    plan(1'b1, 4'h0, mk(0, 0, 0, 0));
    for (int i = 0; i < 20; i++) plan(1'b0, 4'h0, mk(0, 0, 0, 0));
    plan_good(8, mk(0, 0, 0, 0));
    plan(1'b0, 4'h7, mk(1, 0, 0, 0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      drive(st.r, st.k, st.e);
      e = sb.pop_front();
      total++;
      if ({unlock, wtmk, lockout, fail_cnt} !== e)
        $display("FAIL idle_zero step %0d: got u=%b w=%b l=%b fc=%0d, want %b", n, unlock, wtmk, lockout, fail_cnt, e);
      else passed++;
      n++;
    end
  endtask

  task automatic test_reenter();
    step_t st;
    exp_t  e;
    int    n = 0;
    plan_q.delete();
    plan(1'b1, 4'h0, mk(0, 0, 0, 0));
    plan(1'b0, 4'h5, mk(0, 0, 0, 0));
    plan(1'b0, 4'h0, mk(0, 0, 0, 0));
    plan(1'b0, 4'h5, mk(0, 0, 0, 0));
    plan(1'b0, 4'h5, mk(0, 0, 0, 1));
    for (int i = 1; i < 8; i++) plan(1'b0, good_digit(i), mk(0, 0, 0, 1));
    plan(1'b0, 4'h2, mk(1, 0, 0, 1));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      drive(st.r, st.k, st.e);
      e = sb.pop_front();
      total++;
      if ({unlock, wtmk, lockout, fail_cnt} !== e)
        $display("FAIL reenter step %0d: got u=%b w=%b l=%b fc=%0d, want %b", n, unlock, wtmk, lockout, fail_cnt, e);
      else passed++;
      n++;
    end
  endtask

  task automatic test_lockout();
    step_t st;
    exp_t  e;
    int    n = 0;
    plan_q.delete();
    plan(1'b1, 4'h0, mk(0, 0, 0, 0));
    plan(1'b0, 4'h5, mk(0, 0, 0, 0));
    plan(1'b0, 4'h0, mk(0, 0, 0, 0));
    plan(1'b0, 4'h5, mk(0, 0, 0, 0));
    plan(1'b0, 4'h1, mk(0, 0, 0, 1));
    plan(1'b0, 4'h5, mk(0, 0, 0, 1));
    plan(1'b0, 4'h0, mk(0, 0, 0, 1));
    plan(1'b0, 4'h7, mk(0, 0, 0, 2));
    plan(1'b0, 4'h5, mk(0, 0, 0, 2));
    plan(1'b0, 4'h3, mk(0, 0, 0, 3));
    plan_good(8, mk(0, 0, 1, 3));
    plan(1'b0, 4'h4, mk(0, 0, 1, 3));
    plan(1'b0, 4'h4, mk(0, 0, 1, 3));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      drive(st.r, st.k, st.e);
      e = sb.pop_front();
      total++;
      if ({unlock, wtmk, lockout, fail_cnt} !== e)
        $display("FAIL lockout step %0d: got u=%b w=%b l=%b fc=%0d, want %b", n, unlock, wtmk, lockout, fail_cnt, e);
      else passed++;
      n++;
    end
  endtask

  task automatic test_watermark();
    step_t st;
    exp_t  e;
    int    n = 0;
    plan_q.delete();
    plan(1'b1, 4'h0, mk(0, 0, 0, 0));
    plan_good(7, mk(0, 0, 0, 0));
`ifdef WATERMARK_EN
    plan(1'b0, 4'hF, mk(0, 0, 0, 0));
    plan_good(8, mk(0, 0, 0, 0));
    plan(1'b0, 4'h1, mk(1, 1, 0, 0));
    plan(1'b0, 4'h1, mk(1, 1, 0, 0));
`else
    plan(1'b0, 4'hF, mk(0, 0, 0, 1));
    plan_good(8, mk(0, 0, 0, 1));
    plan(1'b0, 4'h1, mk(1, 0, 0, 1));
    plan(1'b0, 4'h1, mk(1, 0, 0, 1));
`endif
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      drive(st.r, st.k, st.e);
      e = sb.pop_front();
      total++;
      if ({unlock, wtmk, lockout, fail_cnt} !== e)
        $display("FAIL watermark step %0d: got u=%b w=%b l=%b fc=%0d, want %b", n, unlock, wtmk, lockout, fail_cnt, e);
      else passed++;
      n++;
    end
  endtask

  task automatic test_watermark_twice();
    step_t st;
    exp_t  e;
    int    n = 0;
    plan_q.delete();
    plan(1'b1, 4'h0, mk(0, 0, 0, 0));
    plan_good(7, mk(0, 0, 0, 0));
`ifdef WATERMARK_EN
    plan(1'b0, 4'hF, mk(0, 0, 0, 0));
    plan_good(7, mk(0, 0, 0, 0));
    plan(1'b0, 4'hF, mk(0, 0, 0, 1));
    plan_good(8, mk(0, 0, 0, 1));
    plan(1'b0, 4'h2, mk(1, 0, 0, 1));
`else
    plan(1'b0, 4'hF, mk(0, 0, 0, 1));
    plan_good(7, mk(0, 0, 0, 1));
    plan(1'b0, 4'hF, mk(0, 0, 0, 2));
    plan_good(8, mk(0, 0, 0, 2));
    plan(1'b0, 4'h2, mk(1, 0, 0, 2));
`endif
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      drive(st.r, st.k, st.e);
      e = sb.pop_front();
      total++;
      if ({unlock, wtmk, lockout, fail_cnt} !== e)
        $display("FAIL watermark_twice step %0d: got u=%b w=%b l=%b fc=%0d, want %b", n, unlock, wtmk, lockout, fail_cnt, e);
      else passed++;
      n++;
    end
  endtask

  // Entered straight from LOCKED, so the first reset also clears lockout.
  task automatic test_reset_mid();
    step_t st;
    exp_t  e;
    int    n = 0;
    plan_q.delete();
    plan(1'b1, 4'h5, mk(0, 0, 0, 0));
    plan_good(6, mk(0, 0, 0, 0));
    plan(1'b1, 4'h4, mk(0, 0, 0, 0));
    plan_good(8, mk(0, 0, 0, 0));
    plan(1'b0, 4'h6, mk(1, 0, 0, 0));
    plan(1'b1, 4'h6, mk(0, 0, 0, 0));
    plan_good(8, mk(0, 0, 0, 0));
    plan(1'b0, 4'h6, mk(1, 0, 0, 0));
    plan(1'b0, 4'h6, mk(1, 0, 0, 0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      drive(st.r, st.k, st.e);
      e = sb.pop_front();
      total++;
      if ({unlock, wtmk, lockout, fail_cnt} !== e)
        $display("FAIL reset_mid step %0d: got u=%b w=%b l=%b fc=%0d, want %b", n, unlock, wtmk, lockout, fail_cnt, e);
      else passed++;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    key = 4'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_unlock();
    test_idle_zero();
    test_reenter();
    test_lockout();
    test_reset_mid();
    test_watermark();
    test_watermark_twice();
    total++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
